line_buffer_ctrl: RTL and testbench
===================================

// Module: line_buffer_ctrl
// PURPOSE
//  Sequencer for line_buffer_unit in a 3-row sliding-window (3xN conv) pipeline; streams one int pixel/cycle.
//  Generates the shared RAM address, write enable and read enable for the two FP8 row RAMs (row-1, row-2).
//  Tracks column/row position, primes the first two rows of a frame, and flags when the 3-row tap is valid.
//  Time-aligns the tap against the int_to_FP8 / RAM / FP8_to_int latencies.
// PARAMETERS
//  IMG_W    64  pixels per row; must be >= 4
//  IMG_H    64  rows per frame; must be >= 3
//  ADDR_W   6   RAM address width; must satisfy 2**ADDR_W >= IMG_W
//  WR_LAT   1   int_to_FP8 latency: cycles from pixel accept to RAM write
//  RD_LAT   2   RAM read + FP8_to_int latency: cycles from read issue to int data at out[1:0]
// PORTS
//  clk        in   1       clock, rising edge
//  reset      in   1       asynchronous, active-high
//  in_valid   in   1       pixel present on datapath in[2]/in[0]
//  in_sof     in   1       qualifies in_valid: first pixel of frame
//  in_ready   out  1       controller accepts pixel (accept = in_valid & in_ready)
//  ram_addr   out  ADDR_W  shared read/write address, both RAMs
//  ram_rd_en  out  1       read strobe, both RAMs
//  ram_wr_en  out  1       write strobe, both RAMs (already WR_LAT-delayed)
//  ram_wr_addr out ADDR_W  write address (WR_LAT-delayed copy of column)
//  tap_valid  out  1       out[1:0] and delayed in[2] form a valid 3-row column
//  tap_col    out  ADDR_W  column index of the current tap
//  frame_done out  1       1-cycle pulse after the last tap of a frame
// BEHAVIOUR
//  Reset: every output 0 except in_ready=0; state IDLE; counters 0; delay lines cleared.
//  FSM states: IDLE, PRIME, RUN, DRAIN.
//   IDLE : in_ready=1; accept with in_sof=1 -> PRIME; col=1, row=0. Accepts without in_sof are dropped (no RAM access).
//   PRIME: rows 0..1; each accept writes RAM; tap_valid never set. End of row 1 -> RUN.
//   RUN  : rows 2..IMG_H-1; each accept reads and writes the same column; tap issued. Last pixel of row IMG_H-1 -> DRAIN.
//   DRAIN: in_ready=0 for max(WR_LAT, RD_LAT) cycles; frame_done pulses on the last cycle -> IDLE.
//  Accept at column c:
//   - ram_addr=c and ram_rd_en=1 in the same cycle (RUN only).
//   - ram_wr_en=1 with ram_wr_addr=c exactly WR_LAT cycles later (PRIME and RUN).
//   - tap_valid=1 with tap_col=c exactly RD_LAT cycles later.
//  Read-before-write: a column is read before it is overwritten, because IMG_W > WR_LAT.
//  Row chaining (datapath): out[0] feeds in[1], so a single address shifts row-1 -> row-2 per column.
//  Counters:
//   - col wraps IMG_W-1 -> 0 and increments row on wrap.
//   - row saturates at IMG_H-1 until DRAIN.
//  Stall: in_valid=0 holds all counters; RAM strobes 0; in-flight delay-line entries still complete on schedule.
//  in_sof=1 in PRIME/RUN (early frame restart): counters reload to col=1, row=0, state PRIME.
//   - Pending writes still commit; pending taps are squashed (tap_valid forced 0).
//  Simultaneous in_sof with the last pixel of a frame: the last pixel wins; the sof is dropped; DRAIN follows.
//  Reset mid-frame: asynchronous clear; delay lines flushed; no write/tap emitted after reset asserts.
// CONFIGURATION
//  LB_CTRL_BORDER_EN defined:
//   - Adds outputs tap_left, tap_right, tap_bottom (1 bit each), registered alongside tap_valid.
//   - tap_left = (tap_col==0); tap_right = (tap_col==IMG_W-1); tap_bottom = (tap row==IMG_H-1).
//   - All three are 0 when tap_valid=0 and at reset.
//  Not defined: ports absent; all other behaviour identical.
// TESTING (IMG_W=8, IMG_H=4, WR_LAT=1, RD_LAT=2)
//  Continuous frame, 32 accepts from sof:
//   - 16 writes and 0 reads in rows 0-1; rd_en on accepts 17..32.
//   - tap_valid pulses 16, tap_col 0..7 twice; frame_done one cycle after DRAIN.
//  Accept at col 7 of row 2:
//   - ram_addr=7 and rd_en that cycle; wr_en with wr_addr=7 next cycle.
//   - tap_col=7 two cycles after accept; next accept uses col 0 / row 3.
//  Bubble of 3 idle cycles in RUN mid-row:
//   - No extra strobes; tap_col sequence continuous; count totals unchanged.
//  in_sof at row 2 col 4: pending write commits; pending taps squashed; next accept addr=1, state PRIME.
//  Reset asserted mid-RUN:
//   - All outputs 0 immediately; in_ready=0.
//   - After release, pixels without in_sof produce no strobes.
//  LB_CTRL_BORDER_EN:
//   - tap_left=1 only at tap_col 0; tap_right=1 only at tap_col 7.
//   - tap_bottom=1 on the final 8 taps of the frame.

Source files
------------

// File: rtl/line_buffer_ctrl_if.sv
// Pixel handshake, row-RAM strobes and tap status shared by line_buffer_ctrl and its datapath.
// Latency: none (wires only). Backpressure: in_ready qualifies in_valid; nothing else stalls.
// Ports: in_valid/in_sof/in_ready, ram_addr/ram_rd_en/ram_wr_en/ram_wr_addr, tap_valid/tap_col, frame_done;
// LB_CTRL_BORDER_EN adds tap_left/tap_right/tap_bottom. slave = controller side, master = datapath side.
interface line_buffer_ctrl_if #(
    parameter int ADDR_W = 6
);
    logic              in_valid;
    logic              in_sof;
    logic              in_ready;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_rd_en;
    logic              ram_wr_en;
    logic [ADDR_W-1:0] ram_wr_addr;
    logic              tap_valid;
    logic [ADDR_W-1:0] tap_col;
    logic              frame_done;
`ifdef LB_CTRL_BORDER_EN
    logic              tap_left;
    logic              tap_right;
    logic              tap_bottom;
`endif

    modport slave (
        input  in_valid, in_sof,
        output in_ready, ram_addr, ram_rd_en, ram_wr_en, ram_wr_addr,
               tap_valid, tap_col, frame_done
`ifdef LB_CTRL_BORDER_EN
        , output tap_left, tap_right, tap_bottom
`endif
    );

    modport master (
        output in_valid, in_sof,
        input  in_ready, ram_addr, ram_rd_en, ram_wr_en, ram_wr_addr,
               tap_valid, tap_col, frame_done
`ifdef LB_CTRL_BORDER_EN
        , input tap_left, tap_right, tap_bottom
`endif
    );
endinterface

// File: rtl/line_buffer_ctrl.sv
// Sequencer for a 3-row sliding-window line buffer: RAM address/strobes, frame position, tap timing.
// Latency: ram_rd_en same cycle as accept, ram_wr_en +WR_LAT, tap_valid +RD_LAT, frame_done after DRAIN.
// Backpressure: in_ready=0 only during DRAIN (and reset); in_valid=0 stalls counters, delay lines keep running.
// Ports: clk, reset (async, active-high), bus (line_buffer_ctrl_if.slave). Optional macro LB_CTRL_BORDER_EN
// adds tap_left/tap_right/tap_bottom border flags registered alongside tap_valid.
module line_buffer_ctrl #(
    parameter int IMG_W  = 64,
    parameter int IMG_H  = 64,
    parameter int ADDR_W = 6,
    parameter int WR_LAT = 1,
    parameter int RD_LAT = 2
) (
    input  logic               clk,
    input  logic               reset,
    line_buffer_ctrl_if.slave  bus
);
    localparam int ROW_W     = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int DRAIN_LEN = (WR_LAT > RD_LAT) ? WR_LAT : RD_LAT;

    localparam logic [ADDR_W-1:0] COL_LAST   = ADDR_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST   = ROW_W'(IMG_H - 1);
    localparam logic [ROW_W-1:0]  ROW_PRIMED = ROW_W'(1);
    localparam logic [7:0]        DRAIN_LAST = 8'(DRAIN_LEN - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PRIME = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    logic [1:0]        state;
    logic [ADDR_W-1:0] col;
    logic [ROW_W-1:0]  row;
    logic [7:0]        drain_cnt;
    logic              frame_done_q;

    logic              ready;
    logic              accept;
    logic              col_last;
    logic              row_last;
    logic              frame_last;
    logic              sof_start;
    logic              px_step;
    logic              wr_issue;
    logic              rd_issue;
    logic [ADDR_W-1:0] wr_col;

    assign ready      = ~reset & (state != ST_DRAIN);
    assign accept     = bus.in_valid & ready;
    assign col_last   = (col == COL_LAST);
    assign row_last   = (row == ROW_LAST);
    assign frame_last = (state == ST_RUN) & col_last & row_last;
    // A sof arriving with the final pixel of a frame is ignored so the frame still drains.
    assign sof_start  = accept & bus.in_sof & ~frame_last;
    assign px_step    = accept & ~sof_start & ((state == ST_PRIME) | (state == ST_RUN));
    // The sof pixel itself is column 0 of row 0, so it primes RAM like any other row-0 pixel.
    assign wr_issue   = sof_start | px_step;
    assign wr_col     = sof_start ? '0 : col;
    // Read-before-write on the same column: the write lands WR_LAT cycles later.
    assign rd_issue   = px_step & (state == ST_RUN);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            col          <= '0;
            row          <= '0;
            drain_cnt    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            if (sof_start) begin
                state <= ST_PRIME;
                col   <= ADDR_W'(1);
                row   <= '0;
            end else if (px_step) begin
                if (col_last) begin
                    col <= '0;
                    if (!row_last) begin
                        row <= row + 1'b1;
                    end
                    if ((state == ST_PRIME) && (row == ROW_PRIMED)) begin
                        state <= ST_RUN;
                    end
                    if ((state == ST_RUN) && row_last) begin
                        state     <= ST_DRAIN;
                        row       <= '0;
                        drain_cnt <= '0;
                    end
                end else begin
                    col <= col + 1'b1;
                end
            end else if (state == ST_DRAIN) begin
                if (drain_cnt == DRAIN_LAST) begin
                    state        <= ST_IDLE;
                    drain_cnt    <= '0;
                    frame_done_q <= 1'b1;
                end else begin
                    drain_cnt <= drain_cnt + 1'b1;
                end
            end
        end
    end

    // Write delay line: matches the int_to_FP8 latency; never squashed so primed data always lands.
    logic [WR_LAT-1:0] wr_vld_sr;
    logic [ADDR_W-1:0] wr_addr_sr [WR_LAT];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_vld_sr <= '0;
            for (int i = 0; i < WR_LAT; i++) wr_addr_sr[i] <= '0;
        end else begin
            wr_vld_sr[0]  <= wr_issue;
            wr_addr_sr[0] <= wr_issue ? wr_col : '0;
            for (int i = 1; i < WR_LAT; i++) begin
                wr_vld_sr[i]  <= wr_vld_sr[i-1];
                wr_addr_sr[i] <= wr_addr_sr[i-1];
            end
        end
    end

    // Tap delay line: matches RAM read + FP8_to_int latency. A frame restart flushes it so
    // taps belonging to the abandoned frame never reach the window.
    logic [RD_LAT-1:0] tap_vld_sr;
    logic [ADDR_W-1:0] tap_col_sr [RD_LAT];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tap_vld_sr <= '0;
            for (int i = 0; i < RD_LAT; i++) tap_col_sr[i] <= '0;
        end else if (sof_start) begin
            tap_vld_sr <= '0;
            for (int i = 0; i < RD_LAT; i++) tap_col_sr[i] <= '0;
        end else begin
            tap_vld_sr[0] <= rd_issue;
            tap_col_sr[0] <= rd_issue ? col : '0;
            for (int i = 1; i < RD_LAT; i++) begin
                tap_vld_sr[i] <= tap_vld_sr[i-1];
                tap_col_sr[i] <= tap_col_sr[i-1];
            end
        end
    end

`ifdef LB_CTRL_BORDER_EN
    // {bottom, right, left}, captured at read issue and carried with the tap.
    logic [2:0] tap_edge_sr [RD_LAT];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < RD_LAT; i++) tap_edge_sr[i] <= '0;
        end else if (sof_start) begin
            for (int i = 0; i < RD_LAT; i++) tap_edge_sr[i] <= '0;
        end else begin
            tap_edge_sr[0] <= rd_issue ? {row_last, col_last, (col == '0)} : 3'b000;
            for (int i = 1; i < RD_LAT; i++) tap_edge_sr[i] <= tap_edge_sr[i-1];
        end
    end

    assign bus.tap_left   = tap_edge_sr[RD_LAT-1][0];
    assign bus.tap_right  = tap_edge_sr[RD_LAT-1][1];
    assign bus.tap_bottom = tap_edge_sr[RD_LAT-1][2];
`endif

    assign bus.in_ready    = ready;
    assign bus.ram_addr    = col;
    assign bus.ram_rd_en   = rd_issue;
    assign bus.ram_wr_en   = wr_vld_sr[WR_LAT-1];
    assign bus.ram_wr_addr = wr_addr_sr[WR_LAT-1];
    assign bus.tap_valid   = tap_vld_sr[RD_LAT-1];
    assign bus.tap_col     = tap_col_sr[RD_LAT-1];
    assign bus.frame_done  = frame_done_q;
endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Bench for line_buffer_ctrl at IMG_W=8, IMG_H=4, WR_LAT=1, RD_LAT=2: directed frames checked every cycle
// against a pixel-index schedule model, plus hand-computed literal expectations on the observed log.
module tb_line_buffer_ctrl;
    localparam int W   = 8;
    localparam int H   = 4;
    localparam int AW  = 3;
    localparam int WRL = 1;
    localparam int RDL = 2;
    localparam int DRN = 2;
    localparam int N   = 1024;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    line_buffer_ctrl_if #(.ADDR_W(AW)) bus ();

    line_buffer_ctrl #(
        .IMG_W(W), .IMG_H(H), .ADDR_W(AW), .WR_LAT(WRL), .RD_LAT(RDL)
    ) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Observed DUT log, one entry per cycle.
    bit obs_rdy [N];
    bit obs_rd  [N];
    bit obs_wr  [N];
    bit obs_tap [N];
    bit obs_fd  [N];
    bit obs_l   [N];
    bit obs_r   [N];
    bit obs_b   [N];
    int obs_addr[N];
    int obs_wa  [N];
    int obs_tc  [N];

    // Model schedule: what must appear in each future cycle.
    bit exp_wr  [N];
    bit exp_tap [N];
    bit exp_fd  [N];
    bit exp_l   [N];
    bit exp_r   [N];
    bit exp_b   [N];
    int exp_wa  [N];
    int exp_tc  [N];

    bit in_frame    = 1'b0;
    int pix         = 0;
    int drain_until = -1;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s @cyc %0d: got %0d, need %0d", name, cyc, act, exp);
        end
    endtask

    task automatic unschedule_taps(input int from);
        for (int k = from; k < N; k++) begin
            exp_tap[k] = 1'b0; exp_tc[k] = 0;
            exp_l[k] = 1'b0; exp_r[k] = 1'b0; exp_b[k] = 1'b0;
        end
    endtask

    always @(negedge clk) begin : model
        bit rdy_e;
        bit acc;
        bit rd_e;
        int ae;
        int c;
        int r;
        obs_rdy[cyc]  = bus.in_ready;
        obs_rd[cyc]   = bus.ram_rd_en;
        obs_addr[cyc] = int'(bus.ram_addr);
        obs_wr[cyc]   = bus.ram_wr_en;
        obs_wa[cyc]   = int'(bus.ram_wr_addr);
        obs_tap[cyc]  = bus.tap_valid;
        obs_tc[cyc]   = int'(bus.tap_col);
        obs_fd[cyc]   = bus.frame_done;
`ifdef LB_CTRL_BORDER_EN
        obs_l[cyc] = bus.tap_left;
        obs_r[cyc] = bus.tap_right;
        obs_b[cyc] = bus.tap_bottom;
`endif
        rd_e = 1'b0;
        ae   = 0;
        rdy_e = 1'b0;
        if (rst) begin
            for (int k = cyc; k < N; k++) begin
                exp_wr[k] = 1'b0; exp_wa[k] = 0; exp_fd[k] = 1'b0;
            end
            unschedule_taps(cyc);
            in_frame = 1'b0; pix = 0; drain_until = -1;
        end else begin
            rdy_e = (cyc > drain_until);
            acc   = bus.in_valid && rdy_e;
            if (acc) begin
                if (bus.in_sof && !(in_frame && pix == W*H-1)) begin
                    unschedule_taps(cyc + 1);
                    exp_wr[cyc+WRL] = 1'b1; exp_wa[cyc+WRL] = 0;
                    in_frame = 1'b1; pix = 1;
                end else if (in_frame) begin
                    c = pix % W;
                    r = pix / W;
                    exp_wr[cyc+WRL] = 1'b1; exp_wa[cyc+WRL] = c;
                    if (r >= 2) begin
                        rd_e = 1'b1; ae = c;
                        exp_tap[cyc+RDL] = 1'b1; exp_tc[cyc+RDL] = c;
                        exp_l[cyc+RDL] = (c == 0);
                        exp_r[cyc+RDL] = (c == W-1);
                        exp_b[cyc+RDL] = (r == H-1);
                    end
                    pix++;
                    if (pix == W*H) begin
                        in_frame = 1'b0; pix = 0;
                        drain_until = cyc + DRN;
                        exp_fd[cyc+DRN+1] = 1'b1;
                    end
                end
            end
        end
        chk("in_ready", int'(bus.in_ready), int'(rdy_e));
        chk("rd_en", int'(bus.ram_rd_en), int'(rd_e));
        if (rd_e || rst) chk("ram_addr", int'(bus.ram_addr), ae);
        chk("wr_en", int'(bus.ram_wr_en), int'(exp_wr[cyc]));
        if (exp_wr[cyc] || rst) chk("wr_addr", int'(bus.ram_wr_addr), exp_wa[cyc]);
        chk("tap_valid", int'(bus.tap_valid), int'(exp_tap[cyc]));
        if (exp_tap[cyc] || rst) chk("tap_col", int'(bus.tap_col), exp_tc[cyc]);
        chk("frame_done", int'(bus.frame_done), int'(exp_fd[cyc]));
`ifdef LB_CTRL_BORDER_EN
        chk("tap_left", int'(bus.tap_left), int'(exp_l[cyc]));
        chk("tap_right", int'(bus.tap_right), int'(exp_r[cyc]));
        chk("tap_bottom", int'(bus.tap_bottom), int'(exp_b[cyc]));
`endif
    end

    task automatic apply(input bit v, input bit s);
        bus.in_valid = v;
        bus.in_sof   = s;
        @(posedge clk);
        #1;
    endtask

    // which: 0 wr, 1 rd, 2 tap, 3 frame_done, 4 left, 5 right, 6 bottom
    function automatic int cnt(input int which, input int lo, input int hi);
        int n = 0;
        for (int t = lo; t <= hi; t++) begin
            case (which)
                0: n += int'(obs_wr[t]);
                1: n += int'(obs_rd[t]);
                2: n += int'(obs_tap[t]);
                3: n += int'(obs_fd[t]);
                4: n += int'(obs_l[t]);
                5: n += int'(obs_r[t]);
                default: n += int'(obs_b[t]);
            endcase
        end
        return n;
    endfunction

    task automatic chk_tap_seq(input string name, input int lo, input int hi);
        int k = 0;
        for (int t = lo; t <= hi; t++) begin
            if (obs_tap[t]) begin
                chk(name, obs_tc[t], k % W);
                k++;
            end
        end
        chk({name, "_count"}, k, 16);
    endtask

    initial begin
        int sa, sb, sc, sd, se;
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Idle pixels without sof are dropped.
        apply(0, 0); apply(1, 0); apply(1, 0); apply(0, 0);

        // Frame A: continuous 32 accepts, valid held through DRAIN.
        sa = cyc;
        apply(1, 1);
        repeat (31) apply(1, 0);
        repeat (3) apply(1, 0);
        repeat (2) apply(0, 0);

        // Frame B: 3-cycle bubble at row 2 col 4.
        sb = cyc;
        apply(1, 1);
        repeat (19) apply(1, 0);
        repeat (3) apply(0, 0);
        repeat (12) apply(1, 0);
        repeat (4) apply(0, 0);

        // Frame C: restart with sof at row 2 col 4, then a full frame.
        sc = cyc;
        apply(1, 1);
        repeat (19) apply(1, 0);
        apply(1, 1);
        repeat (31) apply(1, 0);
        repeat (4) apply(0, 0);

        // Frame D: reset mid-RUN, then pixels without sof.
        sd = cyc;
        apply(1, 1);
        repeat (21) apply(1, 0);
        rst = 1'b1;
        apply(1, 0); apply(1, 0);
        rst = 1'b0;
        repeat (5) apply(1, 0);
        apply(0, 0);

        // Frame E: sof together with the last pixel.
        se = cyc;
        apply(1, 1);
        repeat (30) apply(1, 0);
        apply(1, 1);
        repeat (4) apply(0, 0);

        // Reset state.
        chk("reset_in_ready", int'(obs_rdy[1]), 0);
        chk("reset_tap", int'(obs_tap[1]), 0);
        chk("dropped_no_sof", cnt(0, 3, sa - 1) + cnt(1, 3, sa - 1), 0);

        // Frame A literals.
        chk("A_wr_rows01", cnt(0, sa + 1, sa + 16), 16);
        chk("A_rd_rows01", cnt(1, sa, sa + 15), 0);
        chk("A_rd_rows23", cnt(1, sa + 16, sa + 31), 16);
        chk("A_wr_total", cnt(0, sa, sa + 36), 32);
        chk_tap_seq("A_tap_col", sa, sa + 36);
        chk("A_fd_cycle", int'(obs_fd[sa + 34]), 1);
        chk("A_fd_count", cnt(3, sa, sa + 36), 1);
        chk("A_drain_rdy0", int'(obs_rdy[sa + 32]) + int'(obs_rdy[sa + 33]), 0);
        chk("A_idle_rdy", int'(obs_rdy[sa + 34]), 1);
        chk("A_c7r2_rd", int'(obs_rd[sa + 23]), 1);
        chk("A_c7r2_addr", obs_addr[sa + 23], 7);
        chk("A_c7r2_wr", int'(obs_wr[sa + 24]), 1);
        chk("A_c7r2_wa", obs_wa[sa + 24], 7);
        chk("A_c7r2_tap", obs_tc[sa + 25], 7);
        chk("A_r3c0_addr", obs_addr[sa + 24], 0);

        // Frame B literals.
        chk("B_wr_total", cnt(0, sb, sb + 38), 32);
        chk("B_rd_total", cnt(1, sb, sb + 38), 16);
        chk("B_bubble_quiet", cnt(1, sb + 20, sb + 22), 0);
        chk_tap_seq("B_tap_col", sb, sb + 38);
        chk("B_fd_cycle", int'(obs_fd[sb + 37]), 1);

        // Frame C literals.
        chk("C_prev_tap", obs_tc[sc + 20], 2);
        chk("C_pending_wr", obs_wa[sc + 20], 3);
        chk("C_squash", int'(obs_tap[sc + 21]), 0);
        chk("C_sof_wr", int'(obs_wr[sc + 21]), 1);
        chk("C_sof_wa", obs_wa[sc + 21], 0);
        chk("C_next_addr", obs_addr[sc + 21], 1);
        chk("C_next_no_rd", int'(obs_rd[sc + 21]), 0);
        chk("C_taps", cnt(2, sc + 21, sc + 56), 16);
        chk("C_fd_cycle", int'(obs_fd[sc + 54]), 1);

        // Frame D literals.
        chk("D_rst_rdy", int'(obs_rdy[sd + 22]), 0);
        chk("D_rst_wr", int'(obs_wr[sd + 22]), 0);
        chk("D_rst_tap", int'(obs_tap[sd + 22]), 0);
        chk("D_no_strobes", cnt(0, sd + 22, sd + 29) + cnt(1, sd + 22, sd + 29) + cnt(2, sd + 22, sd + 29), 0);

        // Frame E literals.
        chk("E_sof_dropped_rdy", int'(obs_rdy[se + 32]), 0);
        chk("E_fd_cycle", int'(obs_fd[se + 34]), 1);
        chk("E_taps", cnt(2, se, se + 35), 16);

`ifdef LB_CTRL_BORDER_EN
        chk("A_left", cnt(4, sa, sa + 36), 2);
        chk("A_right", cnt(5, sa, sa + 36), 2);
        chk("A_bottom_last8", cnt(6, sa + 26, sa + 33), 8);
        chk("A_bottom_total", cnt(6, sa, sa + 36), 8);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
